// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet framing constants and transmit state encoding
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        PAYLOAD,
        PAD,
        FCS,
        IFG
    } tx_state_t;

endpackage

// File: rtl/eth_crc32.sv
// rtl/eth_crc32.sv - combinational byte-wise reflected CRC-32 update, shared by tx and rx paths
module eth_crc32
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h000000, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_tx_framer.sv
// rtl/eth_tx_framer.sv - Ethernet transmit framer: preamble, SFD, payload, pad, FCS, IFG
// Optional FCS generation is built in when ETH_TX_FCS_EN is defined.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_BYTES = 7,
    parameter int MIN_PAYLOAD    = 46,
    parameter int MAX_PAYLOAD    = 1500,
    parameter int IFG_BYTES      = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_vld,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       busy,
    output logic       err
);

`ifdef ETH_TX_FCS_EN
    localparam tx_state_t POST_DATA = FCS;
`else
    localparam tx_state_t POST_DATA = IFG;
`endif

    tx_state_t   state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_en_q, tx_en_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [10:0] pay_cnt_q, pay_cnt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [10:0] pay_cnt_inc;

    assign pay_cnt_inc = pay_cnt_q + 11'd1;

`ifdef ETH_TX_FCS_EN
    logic [31:0] crc_q, crc_d, crc_next, fcs_word;
    logic [7:0]  crc_byte;

    assign crc_byte = (state_q == PAD) ? 8'h00 : in_data;
    assign fcs_word = ~crc_q;

    eth_crc32 u_crc (
        .crc_in  (crc_q),
        .data_in (crc_byte),
        .crc_out (crc_next)
    );
`endif

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_en_d   = tx_en_q;
        err_d     = 1'b0;
        pay_cnt_d = pay_cnt_q;
        cnt_d     = cnt_q;
`ifdef ETH_TX_FCS_EN
        crc_d     = crc_q;
`endif
        case (state_q)
            IDLE: begin
                tx_en_d   = 1'b0;
                tx_data_d = 8'h00;
                if (start) begin
                    state_d   = PREAMBLE;
                    tx_en_d   = 1'b1;
                    tx_data_d = ETH_PREAMBLE;
                    cnt_d     = 8'd1;
                    pay_cnt_d = 11'd0;
`ifdef ETH_TX_FCS_EN
                    crc_d     = ETH_CRC_INIT;
`endif
                end
            end
            PREAMBLE: begin
                if (cnt_q == 8'(PREAMBLE_BYTES)) begin
                    state_d   = SFD;
                    tx_data_d = ETH_SFD;
                end else begin
                    tx_data_d = ETH_PREAMBLE;
                    cnt_d     = cnt_q + 8'd1;
                end
            end
            SFD, PAYLOAD: begin
                if (!in_vld) begin
                    // The abort cycle already counts as the first idle byte on the wire.
                    state_d   = IFG;
                    tx_en_d   = 1'b0;
                    tx_data_d = 8'h00;
                    err_d     = 1'b1;
                    cnt_d     = 8'd1;
                end else begin
                    tx_data_d = in_data;
                    pay_cnt_d = pay_cnt_inc;
`ifdef ETH_TX_FCS_EN
                    crc_d     = crc_next;
`endif
                    if (in_last || pay_cnt_q == 11'(MAX_PAYLOAD - 1)) begin
                        err_d   = !in_last;
                        state_d = (pay_cnt_inc < 11'(MIN_PAYLOAD)) ? PAD : POST_DATA;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAD: begin
                tx_data_d = 8'h00;
                pay_cnt_d = pay_cnt_inc;
`ifdef ETH_TX_FCS_EN
                crc_d     = crc_next;
`endif
                if (pay_cnt_inc == 11'(MIN_PAYLOAD)) begin
                    state_d = POST_DATA;
                    cnt_d   = 8'd0;
                end
            end
`ifdef ETH_TX_FCS_EN
            FCS: begin
                case (cnt_q[1:0])
                    2'd0:    tx_data_d = fcs_word[7:0];
                    2'd1:    tx_data_d = fcs_word[15:8];
                    2'd2:    tx_data_d = fcs_word[23:16];
                    default: tx_data_d = fcs_word[31:24];
                endcase
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd3) begin
                    state_d = IFG;
                    cnt_d   = 8'd0;
                end
            end
`endif
            IFG: begin
                tx_en_d   = 1'b0;
                tx_data_d = 8'h00;
                if (cnt_q == 8'(IFG_BYTES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                tx_en_d   = 1'b0;
                tx_data_d = 8'h00;
                cnt_d     = 8'd0;
            end
        endcase
        in_ready_d = (state_d == SFD) || (state_d == PAYLOAD);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            tx_en_q    <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            pay_cnt_q  <= 11'd0;
            cnt_q      <= 8'd0;
`ifdef ETH_TX_FCS_EN
            crc_q      <= ETH_CRC_INIT;
`endif
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_en_q    <= tx_en_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            pay_cnt_q  <= pay_cnt_d;
            cnt_q      <= cnt_d;
`ifdef ETH_TX_FCS_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_en    = tx_en_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb/tb_eth_tx_framer.sv - table-driven self-checking bench for eth_tx_framer
module tb_eth_tx_framer;

`ifdef ETH_TX_FCS_EN
    localparam int FCS_N = 4;
`else
    localparam int FCS_N = 0;
`endif

    typedef struct {
        int         len;
        int         drop_at;
        bit         with_last;
        logic [7:0] base;
        int         exp_acc;
        int         exp_tx;
        int         exp_err;
        int         exp_err_cyc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_vld = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       busy;
    logic       err;

    int n_pass = 0;
    int n_total = 0;

    int got_tx, got_err, got_err_cyc, got_acc, got_gap, got_first, got_holes;
    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    vec_t vecs[9];

    eth_tx_framer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .in_last  (in_last),
        .in_ready (in_ready),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

`ifdef ETH_TX_FCS_EN
    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction
`endif

    task automatic run_frame(input vec_t v, input bit poke);
        int idx = 0;
        int cyc = 0;
        int last_en = 0;
        bit seen = 0;
        bit poked = 0;
        bit done = 0;
        cap_q.delete();
        got_tx = 0; got_err = 0; got_err_cyc = 0; got_acc = 0;
        got_gap = -1; got_first = -1; got_holes = 0;
        start = 1'b1;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (tx_en) begin
                if (got_tx > 0 && last_en != cyc - 1) got_holes++;
                if (got_tx == 0) got_first = cyc;
                cap_q.push_back(tx_data);
                got_tx++;
                last_en = cyc;
            end
            if (err) begin
                got_err++;
                got_err_cyc = cyc;
            end
            if (busy) seen = 1;
            else if (seen) begin
                got_gap = cyc - last_en;
                done = 1;
            end
            if (poke && busy && !tx_en && got_tx > 0 && !poked) begin
                start = 1'b1;
                poked = 1;
            end
            if (idx < v.len && !(in_ready && idx == v.drop_at)) begin
                in_vld  = 1'b1;
                in_data = v.base + 8'(idx);
                in_last = v.with_last && (idx == v.len - 1);
                if (in_ready) begin
                    got_acc++;
                    idx++;
                end
            end else begin
                in_vld  = 1'b0;
                in_last = 1'b0;
            end
        end
        if (!done) chk("frame_timeout", cyc, -1);
        in_vld  = 1'b0;
        in_last = 1'b0;
        start   = 1'b0;
    endtask

    task automatic check_frame(input vec_t v, input bit poke, input string tag);
        int sent;
        int mism = 0;
        int n;
        logic [7:0] b;
`ifdef ETH_TX_FCS_EN
        logic [31:0] crc = 32'hFFFFFFFF;
        logic [31:0] fcs;
`endif
        run_frame(v, poke);
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        sent = (v.drop_at >= 0) ? v.drop_at : ((v.len > 1500) ? 1500 : v.len);
        for (int i = 0; i < sent; i++) begin
            b = v.base + 8'(i);
            exp_q.push_back(b);
`ifdef ETH_TX_FCS_EN
            crc = crc_model(crc, b);
`endif
        end
        if (v.drop_at < 0) begin
            for (int i = sent; i < 46; i++) begin
                exp_q.push_back(8'h00);
`ifdef ETH_TX_FCS_EN
                crc = crc_model(crc, 8'h00);
`endif
            end
`ifdef ETH_TX_FCS_EN
            fcs = ~crc;
            for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
`endif
        end
        n = (exp_q.size() > cap_q.size()) ? exp_q.size() : cap_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= exp_q.size() || i >= cap_q.size()) mism++;
            else if (exp_q[i] !== cap_q[i]) mism++;
        end
        chk({tag, "_first_tx_cycle"}, got_first, 1);
        chk({tag, "_accepted"}, got_acc, v.exp_acc);
        chk({tag, "_tx_en_cycles"}, got_tx, v.exp_tx);
        chk({tag, "_tx_en_holes"}, got_holes, 0);
        chk({tag, "_err_pulses"}, got_err, v.exp_err);
        chk({tag, "_err_cycle"}, got_err_cyc, v.exp_err_cyc);
        chk({tag, "_idle_gap"}, got_gap, 12);
        chk({tag, "_stream_bad_bytes"}, mism, 0);
    endtask

    initial begin
        int idx;
        int cnt;
        bit hit;

        vecs[0] = '{60,   -1, 1'b1, 8'h00, 60,   8 + 60 + FCS_N,   0, 0};
        vecs[1] = '{1,    -1, 1'b1, 8'hAB, 1,    8 + 46 + FCS_N,   0, 0};
        vecs[2] = '{60,   10, 1'b1, 8'h40, 10,   18,               1, 19};
        vecs[3] = '{46,   -1, 1'b1, 8'h10, 46,   8 + 46 + FCS_N,   0, 0};
        vecs[4] = '{45,   -1, 1'b1, 8'h20, 45,   8 + 46 + FCS_N,   0, 0};
        vecs[5] = '{47,   -1, 1'b1, 8'h30, 47,   8 + 47 + FCS_N,   0, 0};
        vecs[6] = '{5,     0, 1'b1, 8'h77, 0,    8,                1, 9};
        vecs[7] = '{1501, -1, 1'b0, 8'h00, 1500, 8 + 1500 + FCS_N, 1, 1508};
        vecs[8] = '{1500, -1, 1'b1, 8'hC0, 1500, 8 + 1500 + FCS_N, 0, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx_en", int'(tx_en), 0);
        chk("reset_tx_data", int'(tx_data), 0);
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_err", int'(err), 0);

        for (int r = 0; r < 9; r++) check_frame(vecs[r], 1'b0, $sformatf("vec%0d", r));

        // Reset while payload byte 20 is being offered.
        idx = 0;
        hit = 0;
        start = 1'b1;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (in_ready && idx == 20) begin
                rst = 1'b1;
                hit = 1;
            end else if (in_ready) begin
                idx++;
            end
            in_vld  = 1'b1;
            in_data = 8'(idx);
        end
        chk("rst_reached_byte20", int'(hit), 1);
        @(negedge clk);
        chk("rst_mid_tx_en", int'(tx_en), 0);
        chk("rst_mid_in_ready", int'(in_ready), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_tx_data", int'(tx_data), 0);
        rst = 1'b0;
        in_vld = 1'b0;
        @(negedge clk);

        check_frame(vecs[1], 1'b1, "after_rst_ifg_start");
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || tx_en) cnt++;
        end
        chk("ifg_start_not_queued", cnt, 0);
        check_frame(vecs[0], 1'b0, "clean_after_ifg");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
